// File: rtl/smpl_ifetch_queue.sv
// rtl/smpl_ifetch_queue.sv - SMPL instruction prefetch queue with redirect flush
// Optional stall_cycles counter output is enabled by defining SMPL_IFQ_STALL_CNT_EN.
module smpl_ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [12:0] RESET_PC = 13'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [12:0] redirect_addr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_data,
  output logic [12:0] instr_addr,
  output logic        mem_req,
  output logic [12:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
`ifdef SMPL_IFQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [12:0]   fetch_pc, fetch_pc_n;
  logic [12:0]   mem_addr_n;
  logic          drop, drop_n;
  logic [15:0]   fifo_data [DEPTH];
  logic [12:0]   fifo_addr [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n, head_ptr;
  logic [AW:0]   count, count_n, count_after_pop;
  logic          pop, push;
  logic [15:0]   head_data_n;
  logic [12:0]   head_addr_n;

  assign mem_req         = (state == BUSY);
  assign pop             = instr_valid && instr_ready && !redirect;
  assign count_after_pop = count - (AW+1)'(pop);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    mem_addr_n = mem_addr;
    drop_n     = drop;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          state_n    = BUSY;
          fetch_pc_n = redirect_addr;
          mem_addr_n = redirect_addr;
          drop_n     = 1'b0;
        end else if (count < FULL_COUNT) begin
          state_n    = BUSY;
          mem_addr_n = fetch_pc;
        end
      end
      BUSY: begin
        if (redirect) begin
          fetch_pc_n = redirect_addr;
          // An in-flight request cannot be aborted; its word is dropped on ack.
          if (mem_ack) begin
            mem_addr_n = redirect_addr;
            drop_n     = 1'b0;
          end else begin
            drop_n     = 1'b1;
          end
        end else if (mem_ack) begin
          if (drop) begin
            drop_n     = 1'b0;
            mem_addr_n = fetch_pc;
          end else begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc + 13'd1;
            if (count_after_pop < (FULL_COUNT - ONE))
              mem_addr_n = fetch_pc + 13'd1;
            else
              state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n  = redirect ? '0 : count_after_pop + (AW+1)'(push);
    rd_ptr_n = redirect ? '0 : rd_ptr + AW'(pop);
    wr_ptr_n = redirect ? '0 : wr_ptr + AW'(push);
    head_ptr = rd_ptr + AW'(pop);
    // The incoming word becomes the head only when nothing older remains.
    if (push && (count_after_pop == '0)) begin
      head_data_n = mem_rdata;
      head_addr_n = fetch_pc;
    end else begin
      head_data_n = fifo_data[head_ptr];
      head_addr_n = fifo_addr[head_ptr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      mem_addr    <= RESET_PC;
      drop        <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr_data  <= 16'h0000;
      instr_addr  <= 13'h0000;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_addr <= mem_addr_n;
      drop     <= drop_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      count    <= count_n;
      if (redirect) begin
        instr_valid <= 1'b0;
      end else begin
        instr_valid <= (count_n != '0);
        if (count_n != '0) begin
          instr_data <= head_data_n;
          instr_addr <= head_addr_n;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_addr[wr_ptr] <= fetch_pc;
    end
  end

`ifdef SMPL_IFQ_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= 16'h0000;
    else if (instr_ready && !instr_valid && !redirect && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_smpl_ifetch_queue.sv
// tb/tb_smpl_ifetch_queue.sv - directed self-checking bench for smpl_ifetch_queue
module tb_smpl_ifetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [12:0] redirect_addr = 13'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data;
  logic [12:0] instr_addr;
  logic        mem_req;
  logic [12:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
`ifdef SMPL_IFQ_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] s0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit found;

  int          lat = 0;
  bit          mem_en = 1'b1;
  int          wait_cnt = 0;
  logic        model_ack = 1'b0;
  logic [15:0] model_rdata = 16'h0000;
  logic        man_ack = 1'b0;
  logic [15:0] man_rdata = 16'h0000;
  logic [12:0] wrap_seq [4];

  assign mem_ack   = mem_en ? model_ack : man_ack;
  assign mem_rdata = mem_en ? model_rdata : man_rdata;

  always #5 clock = ~clock;

  smpl_ifetch_queue dut (
    .clock(clock),
    .reset(reset),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data(instr_data),
    .instr_addr(instr_addr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef SMPL_IFQ_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  function automatic logic [15:0] word_of(input logic [12:0] a);
    return {3'b101, a} ^ 16'h0C3C;
  endfunction

  // Memory with lat wait cycles before the acking cycle.
  always @(negedge clock) begin
    if (mem_req && mem_en) begin
      if (wait_cnt >= lat) begin
        model_ack   = 1'b1;
        model_rdata = word_of(mem_addr);
        wait_cnt    = 0;
      end else begin
        model_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      model_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    redirect = 1'b0;
    man_ack  = 1'b0;
    step();
    step();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 13'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 16'h0000);
    chk("rst_addr", instr_addr, 13'h0000);
    reset = 1'b0;
  endtask

  initial begin
    // Streaming with zero-wait memory and an always-ready core.
    mem_en = 1'b1; lat = 0; instr_ready = 1'b1;
    do_reset();
    step();
    chk("t1_valid_e1", instr_valid, 1'b0);
    chk("t1_req_e1", mem_req, 1'b1);
    chk("t1_maddr_e1", mem_addr, 13'h0000);
    step();
    chk("t1_valid_e2", instr_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("t1_iaddr", instr_addr, 32'(k));
      chk("t1_idata", instr_data, {16'h0, word_of(13'(k))});
      chk("t1_maddr", mem_addr, 32'(k + 1));
      step();
    end

    // Core stalled: queue fills to DEPTH and fetch stops.
    instr_ready = 1'b0;
    do_reset();
    step();
    repeat (4) step();
    chk("t2_req_full", mem_req, 1'b0);
    chk("t2_maddr_full", mem_addr, 13'h0003);
    chk("t2_valid", instr_valid, 1'b1);
    chk("t2_head", instr_addr, 13'h0000);
    repeat (3) step();
    chk("t2_req_hold", mem_req, 1'b0);
    chk("t2_maddr_hold", mem_addr, 13'h0003);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t2_head_pop", instr_addr, 13'h0001);
    chk("t2_req_pop", mem_req, 1'b0);
    step();
    chk("t2_req_refill", mem_req, 1'b1);
    chk("t2_maddr_refill", mem_addr, 13'h0004);
    step();
    chk("t2_req_refull", mem_req, 1'b0);
    chk("t2_head_keep", instr_addr, 13'h0001);

    // Redirect during the second wait cycle of a 3-cycle request.
    mem_en = 1'b1; lat = 2; instr_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (mem_req && mem_addr == 13'h0005) begin
        found = 1'b1;
        break;
      end
    end
    chk("t3_reach_0005", found, 1'b1);
    step();
    redirect = 1'b1; redirect_addr = 13'h0100;
    step();
    redirect = 1'b0;
    chk("t3_maddr_held", mem_addr, 13'h0005);
    chk("t3_req_held", mem_req, 1'b1);
    chk("t3_valid_flush", instr_valid, 1'b0);
    step();
    chk("t3_maddr_new", mem_addr, 13'h0100);
    chk("t3_no_drop_word", instr_valid, 1'b0);
    step();
    chk("t3_wait1", instr_valid, 1'b0);
    step();
    chk("t3_wait2", instr_valid, 1'b0);
    step();
    chk("t3_valid_new", instr_valid, 1'b1);
    chk("t3_iaddr_new", instr_addr, 13'h0100);
    chk("t3_idata_new", instr_data, word_of(13'h0100));

    // Redirect coinciding with mem_ack and a pop.
    mem_en = 1'b0; man_ack = 1'b0; instr_ready = 1'b0;
    do_reset();
    step();
    chk("t4_maddr0", mem_addr, 13'h0000);
    man_ack = 1'b1; man_rdata = word_of(13'h0000);
    step();
    chk("t4_valid0", instr_valid, 1'b1);
    chk("t4_maddr1", mem_addr, 13'h0001);
    man_rdata = word_of(13'h0001);
    step();
    chk("t4_maddr2", mem_addr, 13'h0002);
    man_rdata = word_of(13'h0002);
    redirect = 1'b1; redirect_addr = 13'h0040; instr_ready = 1'b1;
    step();
    redirect = 1'b0;
    chk("t4_valid_flush", instr_valid, 1'b0);
    chk("t4_maddr_redir", mem_addr, 13'h0040);
    chk("t4_req_busy", mem_req, 1'b1);
    chk("t4_iaddr_hold", instr_addr, 13'h0000);
    man_rdata = word_of(13'h0040);
    step();
    man_ack = 1'b0;
    chk("t4_valid_new", instr_valid, 1'b1);
    chk("t4_iaddr_new", instr_addr, 13'h0040);
    chk("t4_idata_new", instr_data, word_of(13'h0040));

    // Fetch address wrap.
    mem_en = 1'b1; lat = 0; instr_ready = 1'b1;
    do_reset();
    step();
    redirect = 1'b1; redirect_addr = 13'h1FFE;
    step();
    redirect = 1'b0;
    chk("t5_maddr", mem_addr, 13'h1FFE);
    chk("t5_valid_flush", instr_valid, 1'b0);
    wrap_seq[0] = 13'h1FFE; wrap_seq[1] = 13'h1FFF;
    wrap_seq[2] = 13'h0000; wrap_seq[3] = 13'h0001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_valid", instr_valid, 1'b1);
      chk("t5_iaddr", instr_addr, wrap_seq[k]);
    end

`ifdef SMPL_IFQ_STALL_CNT_EN
    mem_en = 1'b1; lat = 2; instr_ready = 1'b1;
    do_reset();
    chk("t6_stall_rst", stall_cycles, 16'h0000);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_first_word", found, 1'b1);
    for (int r = 0; r < 2; r++) begin
      s0 = stall_cycles;
      repeat (3) step();
      chk("t6_next_word", instr_valid, 1'b1);
      chk("t6_stall_delta", stall_cycles - s0, 16'd2);
    end
    mem_en = 1'b0; man_ack = 1'b0;
    repeat (65540) step();
    chk("t6_stall_sat", stall_cycles, 16'hFFFF);
    repeat (3) step();
    chk("t6_stall_sat_hold", stall_cycles, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/smpl_ifetch_queue.md
Name: smpl_ifetch_queue

Overview:
- Instruction prefetch stage between the SMPL instruction memory and the SMPL core's instruction port.
- Fetches sequential 16-bit instruction words ahead of the core and buffers them in a small FIFO.
- Presents them to the core via valid/ready, tagged with their 13-bit address.
- A redirect from the core (JMP, taken JZ) flushes the queue and restarts fetch at the new address.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 13'h0000, first fetch address after reset.

Ports:
- clock  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- redirect  input  1  core request to flush and restart fetch; single-cycle pulse.
- redirect_addr  input  13  new fetch address; valid when redirect=1.
- instr_valid  output  1  head entry valid.
- instr_ready  input  1  core accepts head entry.
- instr_data  output  16  head instruction word.
- instr_addr  output  13  address of head word.
- mem_req  output  1  instruction memory read request (registered).
- mem_addr  output  13  instruction memory address (registered).
- mem_ack  input  1  memory returns mem_rdata this cycle; completes current request.
- mem_rdata  input  16  instruction word; valid when mem_ack=1.

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_addr=0.
  - FIFO empty; FSM=IDLE; fetch_pc=RESET_PC; drop=0.
- Interface rules:
  - Reset is asynchronous, active-high; clock is `clock`.
  - Reset mid-request abandons the request; memory must tolerate mem_req falling without ack.
- FSM states:
  - IDLE: mem_req=0.
  - BUSY: mem_req=1; mem_addr held stable until mem_ack.
  - Only one request is outstanding at a time.
- Space rule: issue allowed when (count + outstanding) < DEPTH. The outstanding bit is 1 in BUSY.
- IDLE -> BUSY: when space is available. mem_addr <= fetch_pc at the same edge; mem_req is high the following cycle.
- BUSY with mem_ack, drop=0:
  - Write {fetch_pc, mem_rdata} into FIFO; fetch_pc <= fetch_pc+1.
  - If space remains after this write (counting a same-cycle pop): stay BUSY with mem_addr <= fetch_pc+1, giving back-to-back requests. Otherwise go to IDLE.
  - With zero-wait memory, throughput is 1 word/cycle.
- fetch_pc is 13-bit and wraps 13'h1FFF -> 13'h0000 silently.
- Latency: a word acked at edge N has instr_valid=1 after edge N when the FIFO was empty (no bypass).
- Pop: instr_valid && instr_ready at the edge removes the head. Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
- Redirect (highest priority):
  - FIFO flushed (count=0, instr_valid=0 next cycle); any same-cycle pop is ignored.
  - fetch_pc <= redirect_addr.
  - In IDLE: next state BUSY, mem_addr <= redirect_addr.
  - In BUSY without mem_ack: the request cannot be aborted. Set drop=1 and keep mem_req/mem_addr until ack. The acked word is discarded and drop cleared; the next request uses redirect_addr.
  - In BUSY with mem_ack in the same cycle: acked word discarded; mem_addr <= redirect_addr, stay BUSY.
  - Second redirect while drop=1: fetch_pc takes the newest redirect_addr; drop stays 1.
- Full: mem_req not raised while (count + outstanding) == DEPTH. Empty: instr_valid=0; instr_data/instr_addr hold their last values.
- mem_ack while in IDLE: ignored.

Optional Feature:
- Macro: SMPL_IFQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles [15:0], reset 0.
  - Increments every cycle with instr_ready=1 and instr_valid=0, excluding the redirect cycle.
  - Saturates at 16'hFFFF.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset release, memory acks every cycle, instr_ready=1 -> mem_addr 0000,0001,0002...; instr_addr/instr_data stream in order; first instr_valid two cycles after reset release.
- instr_ready=0, zero-wait memory, DEPTH=4 -> exactly 4 words buffered (addr 0-3); mem_req drops; mem_addr never exceeds 0003 until a pop.
- Memory with 3-cycle latency; redirect to 0x0100 in second wait cycle of request 0x0005 -> mem_addr held at 0005 until ack; that word never appears; next mem_addr=0100; first instr_addr=0100.
- Redirect to 0x0040 coincident with mem_ack and instr_ready -> FIFO empty next cycle, acked word dropped, mem_addr=0040 next cycle.
- redirect_addr=0x1FFE, continuous fetch -> instr_addr sequence 1FFE, 1FFF, 0000, 0001.
- With SMPL_IFQ_STALL_CNT_EN and 3-cycle memory latency, instr_ready=1 -> stall_cycles increases by 2 per delivered word in steady state; saturates at FFFF under forced stall.
